// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode instruction FIFO holding {pc, inst} pairs, with flush and overflow pulse.
module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inWe,
  input  logic [31:0] inPc,
  input  logic [31:0] inInst,
  input  logic        flush,
  input  logic        outRe,
  output logic        outValid,
  output logic [31:0] outPc,
  output logic [31:0] outInst,
  output logic        full,
  output logic [4:0]  count,
  output logic        ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic push, pop;
  assign full     = count == 5'(DEPTH);
  assign outValid = count != 5'd0;
  assign push     = inWe && !full;
  assign pop      = outRe && outValid;
  // Invalid slots are masked to NOP so stale storage never leaks out.
  assign outPc    = outValid ? pc_mem[rd_ptr] : 32'h0;
  assign outInst  = outValid ? inst_mem[rd_ptr] : 32'h0;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + 5'(push) - 5'(pop);
      ovf    <= inWe && full;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= inPc;
      inst_mem[wr_ptr] <= inInst;
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed self-checking bench for inst_queue (DEPTH=4).
module tb_inst_queue;
  logic        clk = 0;
  logic        rst, inWe, flush, outRe;
  logic [31:0] inPc, inInst;
  logic        outValid, full, ovf;
  logic [31:0] outPc, outInst;
  logic [4:0]  count;
  int total = 0;
  int bad = 0;

  inst_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .inWe(inWe), .inPc(inPc), .inInst(inInst),
    .flush(flush), .outRe(outRe), .outValid(outValid), .outPc(outPc),
    .outInst(outInst), .full(full), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step(input logic we, input logic [31:0] pc, input logic [31:0] inst,
                      input logic re, input logic fl, input logic r);
    inWe = we; inPc = pc; inInst = inst; outRe = re; flush = fl; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    inWe = 0; inPc = 0; inInst = 0; outRe = 0; flush = 0; rst = 1;
    #1;
    step(1, 32'h44, 32'h55, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_count", count, 0);
    chk("rst_valid", outValid, 0);
    chk("rst_full", full, 0);
    chk("rst_pc", outPc, 0);
    chk("rst_inst", outInst, 0);
    chk("rst_ovf", ovf, 0);

    step(1, 32'h0, 32'hA0, 0, 0, 0);
    chk("lat1_valid", outValid, 1);
    chk("lat1_pc", outPc, 32'h0);
    step(1, 32'h4, 32'hA4, 0, 0, 0);
    step(1, 32'h8, 32'hA8, 0, 0, 0);
    chk("p3_count", count, 3);
    chk("p3_pc", outPc, 32'h0);
    chk("p3_inst", outInst, 32'hA0);
    chk("p3_full", full, 0);

    step(1, 32'hC, 32'hAC, 0, 0, 0);
    chk("p4_count", count, 4);
    chk("p4_full", full, 1);
    chk("p4_ovf", ovf, 0);
    step(1, 32'h10, 32'hB0, 0, 0, 0);
    chk("p5_count", count, 4);
    chk("p5_ovf", ovf, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("ovf_once", ovf, 0);
    chk("drop_head", outPc, 32'h0);

    step(1, 32'h20, 32'hC0, 1, 0, 0);
    chk("fullpop_count", count, 3);
    chk("fullpop_ovf", ovf, 1);
    chk("pop1_pc", outPc, 32'h4);
    chk("pop1_inst", outInst, 32'hA4);
    step(0, 0, 0, 1, 0, 0);
    chk("pop2_pc", outPc, 32'h8);
    chk("pop2_ovf", ovf, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("pop3_pc", outPc, 32'hC);
    step(0, 0, 0, 1, 0, 0);
    chk("pop4_valid", outValid, 0);
    chk("pop4_inst", outInst, 0);
    chk("pop4_pc", outPc, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("under_count", count, 0);

    step(1, 32'h100, 32'h900, 0, 0, 0);
    step(1, 32'h104, 32'h904, 0, 0, 0);
    chk("pp_start", count, 2);
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h108 + 4 * i, 32'h908 + 4 * i, 1, 0, 0);
      chk($sformatf("pp_count%0d", i), count, 2);
      chk($sformatf("pp_pc%0d", i), outPc, 32'h104 + 4 * i);
      chk($sformatf("pp_inst%0d", i), outInst, 32'h904 + 4 * i);
    end

    step(1, 32'h200, 32'hE00, 0, 0, 0);
    chk("fl_pre", count, 3);
    step(1, 32'h300, 32'hF00, 1, 1, 0);
    chk("fl_count", count, 0);
    chk("fl_valid", outValid, 0);
    chk("fl_pc", outPc, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("fl_absent", count, 0);

    for (int i = 0; i < 4; i++) step(1, 32'h500 + 4 * i, 32'h600 + 4 * i, 0, 0, 0);
    chk("fl2_full", full, 1);
    step(1, 32'h510, 32'h610, 0, 1, 0);
    chk("fl2_ovf", ovf, 0);
    chk("fl2_count", count, 0);
    step(1, 32'h700, 32'h800, 0, 0, 0);
    chk("fl2_wr0_pc", outPc, 32'h700);

    step(1, 32'h704, 32'h804, 0, 0, 0);
    chk("mid_pre", count, 2);
    step(1, 32'h708, 32'h808, 1, 0, 1);
    chk("mid_count", count, 0);
    chk("mid_full", full, 0);
    chk("mid_ovf", ovf, 0);
    chk("mid_valid", outValid, 0);
    step(1, 32'h40, 32'h1234, 0, 0, 0);
    chk("post_valid", outValid, 1);
    chk("post_pc", outPc, 32'h40);
    chk("post_inst", outInst, 32'h1234);
    chk("post_count", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 inWe  input  1  fetch-side write request; tied to the fetch stage's ROM enable.
REQ-005 inPc  input  32  PC of the instruction being written.
REQ-006 inInst  input  32  instruction word read from ROM for inPc.
REQ-007 flush  input  1  discard all queued entries (branch/jump redirect).
REQ-008 outRe  input  1  decode-side accept of the head entry.
REQ-009 outValid  output  1  head entry present.
REQ-010 outPc  output  32  PC of head entry.
REQ-011 outInst  output  32  instruction of head entry.
REQ-012 full  output  1  queue holds DEPTH entries; stalls fetch.
REQ-013 count  output  5  number of valid entries, 0..DEPTH.
REQ-014 ovf  output  1  registered one-cycle pulse: a write was dropped.

Function
REQ-015 Storage SHALL be DEPTH entries of {pc[31:0], inst[31:0]} with write pointer wrPtr, read pointer rdPtr and an occupancy counter.
REQ-016 Pointers SHALL wrap modulo DEPTH; pointer width log2(DEPTH).
REQ-017 full SHALL equal (count == DEPTH), combinational from registered count.
REQ-018 outValid SHALL equal (count != 0), combinational from registered count.
REQ-019 outPc/outInst SHALL present the entry at rdPtr combinationally when outValid=1; SHALL be 32'h0 (NOP) when outValid=0.
REQ-020 Push: inWe=1 and full=0 SHALL write {inPc, inInst} at wrPtr and advance wrPtr by 1 at the clock edge.
REQ-021 Pop: outRe=1 and outValid=1 SHALL advance rdPtr by 1 at the clock edge; outRe with outValid=0 SHALL be ignored.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; entry data SHALL be written and read correctly, including when the queue is empty, which gives no same-cycle bypass.
REQ-023 When full=1, inWe=1 SHALL be dropped even if a pop occurs that cycle; ovf SHALL be 1 in the next cycle only.
REQ-024 Data written SHALL become visible at the outputs one cycle after the push edge (latency 1).
REQ-025 flush=1 SHALL, at the edge, set wrPtr=0, rdPtr=0, count=0, and discard the same-cycle push and pop; ovf SHALL be 0 next cycle.
REQ-026 Priority SHALL be rst > flush > push/pop.
REQ-027 count SHALL never exceed DEPTH nor underflow below 0 under any input combination.

Reset
REQ-028 rst=1 at a rising edge SHALL set wrPtr=0, rdPtr=0, count=0 and ovf=0, irrespective of inWe, outRe and flush.
REQ-029 After reset, outValid=0, full=0, outPc=0 and outInst=0 SHALL hold until the first push.
REQ-030 Storage contents SHALL need no reset; they SHALL never be visible while their entry is invalid.
REQ-031 Reset asserted mid-operation, with the queue partly full, SHALL empty the queue at that edge.

Verification
REQ-032 Reset, then push PC 0x0/0x4/0x8 with inst 0xA0/0xA4/0xA8 and outRe=0 -> count=3, outPc=0x0, outInst=0xA0, full=0.
REQ-033 Push 5 entries into DEPTH=4 with outRe=0 -> full=1 after the 4th; the 5th is dropped, ovf pulses once, and count stays 4.
REQ-034 Full queue, then outRe=1 for 4 cycles -> outPc sequence 0x0, 0x4, 0x8, 0xC; then outValid=0 and outInst=0.
REQ-035 Continuous push and pop for 10 cycles starting at count=2 -> count stays 2, pointers wrap, and outPc increases by 4 per cycle in order.
REQ-036 count=3 with flush=1, inWe=1 and outRe=1 the same cycle -> next cycle count=0, outValid=0, and the pushed entry is absent.
REQ-037 count=2 with rst=1 and flush=0 -> next cycle count=0, full=0, ovf=0; a subsequent push of PC 0x40 appears at the head after 1 cycle.
